uart_frame_streamer: RTL and testbench

- Parametrised successor to the fixed 13-input UART formatter in the voltmeter top.
- Snapshots CHANNELS 16-bit BCD readings (4 digits, D.DDD volts) coherently and serialises them as an ASCII text frame.
- Writes the frame one byte at a time into the existing uart FIFO interface.
- Adds a per-channel enable mask, continuous or single-shot triggering, an overrun flag and a frame-done strobe.

---
 rtl/uart_frame_streamer.sv | 120 ++++++++++++
 tb/tb_uart_frame_streamer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer: snapshots CHANNELS BCD readings and streams them as an ASCII
// text frame ("NN:D.DDD " per enabled channel, then CR LF) into a UART FIFO.
module uart_frame_streamer #(
  parameter int CHANNELS      = 13,
  parameter int PERIOD_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    trigger,
  input  logic [CHANNELS-1:0]     ch_mask,
  input  logic [16*CHANNELS-1:0]  din,
  input  logic                    tx_full,
  output logic [7:0]              w_data,
  output logic                    wr_uart,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);
  localparam int CW = $clog2(CHANNELS + 1);
  localparam int PW = $clog2(PERIOD_CYCLES);
  typedef enum logic [2:0] {IDLE, SELECT, EMIT, GAP, EOL, DONE} state_t;
  state_t                  r_state;
  logic [PW-1:0]           r_cnt;
  logic [CHANNELS-1:0]     r_mask;
  logic [16*CHANNELS-1:0]  r_din;
  logic [CW-1:0]           r_ch;
  logic [3:0]              r_bidx;
  logic                    r_tail;
  logic [7:0]              r_wdata;
  logic                    r_ovr;
  logic                    w_wrap;
  logic                    w_start;
  logic                    w_last_ch;
  logic [15:0]             w_val;

  function automatic logic [7:0] f_asc(input logic [3:0] n);
    return n > 4'd9 ? 8'h3F : {4'h3, n};
  endfunction

  function automatic logic [7:0] f_byte(input logic [CW-1:0] c, input logic [3:0] b, input logic [15:0] v);
    int ci;
    ci = int'(c);
    return b == 4'd0 ? 8'(48 + ci / 10) :
           b == 4'd1 ? 8'(48 + ci % 10) :
           b == 4'd2 ? 8'h3A :
           b == 4'd3 ? f_asc(v[15:12]) :
           b == 4'd4 ? 8'h2E :
           b == 4'd5 ? f_asc(v[11:8]) :
           b == 4'd6 ? f_asc(v[7:4]) :
           b == 4'd7 ? f_asc(v[3:0]) : 8'h20;
  endfunction

  assign w_wrap     = enable & ~mode & (r_cnt == PW'(PERIOD_CYCLES - 1));
  assign w_start    = w_wrap | (trigger & enable & mode);
  assign w_last_ch  = r_ch == CW'(CHANNELS - 1);
  assign w_val      = r_din[{r_ch, 4'd0} +: 16];
  assign w_data     = r_wdata;
  assign wr_uart    = (r_state == EMIT) & ~tx_full;
  assign busy       = r_state != IDLE;
  assign frame_done = r_state == DONE;
  assign overrun    = r_ovr;

  // r_tail marks the CR/LF trailer; r_bidx then counts 0=CR, 1=LF
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_din   <= '0;
      r_ch    <= '0;
      r_bidx  <= '0;
      r_tail  <= 1'b0;
      r_wdata <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_cnt <= (enable & ~mode & ~w_wrap) ? r_cnt + 1'b1 : '0;
      if (w_start && r_state != IDLE) r_ovr <= 1'b1;
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= SELECT;
          r_din   <= din;
          r_mask  <= ch_mask;
          r_ch    <= '0;
          r_tail  <= 1'b0;
        end
        SELECT: if (r_ch == CW'(CHANNELS)) r_state <= EOL;
          else if (r_mask[r_ch]) begin
            r_state <= EMIT;
            r_bidx  <= '0;
            r_wdata <= f_byte(r_ch, 4'd0, w_val);
          end else r_ch <= r_ch + 1'b1;
        EMIT: if (!tx_full) r_state <= GAP;
        GAP: if (r_tail) begin
            if (r_bidx == 4'd0) begin
              r_state <= EMIT;
              r_bidx  <= 4'd1;
              r_wdata <= 8'h0A;
            end else r_state <= DONE;
          end else if (r_bidx == 4'd8) begin
            r_ch    <= r_ch + 1'b1;
            r_state <= w_last_ch ? EOL : SELECT;
          end else begin
            r_state <= EMIT;
            r_bidx  <= r_bidx + 4'd1;
            r_wdata <= f_byte(r_ch, r_bidx + 4'd1, w_val);
          end
        EOL: begin
          r_state <= EMIT;
          r_tail  <= 1'b1;
          r_bidx  <= '0;
          r_wdata <= 8'h0D;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_streamer.sv
// tb_uart_frame_streamer: vector table plus hand-written stall, continuous,
// reset and overrun sequences; every written byte is checked against a queue.
module tb_uart_frame_streamer;
  localparam int CH = 13;
  localparam int PER = 200;
  logic clk = 0, rst = 0, enable = 0, mode = 1, trigger = 0, tx_full = 0;
  logic [CH-1:0] ch_mask = '0;
  logic [16*CH-1:0] din = '0;
  logic [7:0] w_data;
  logic wr_uart, busy, frame_done, overrun;
  int total = 0, bad = 0, cyc = 0, n_wr = 0, n_done = 0, first_wr = -1;
  logic prev_wr = 0;
  logic [7:0] exp_q[$], got_q[$];

  typedef struct {
    logic [CH-1:0] mask;
    logic [15:0] d0, d2, d12;
    int nbytes;
  } vec_t;
  vec_t vt[5];

  uart_frame_streamer #(.CHANNELS(CH), .PERIOD_CYCLES(PER)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .trigger(trigger),
    .ch_mask(ch_mask), .din(din), .tx_full(tx_full), .w_data(w_data),
    .wr_uart(wr_uart), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_uart) begin
      chk("wr_while_full", tx_full, 0);
      chk("wr_back_to_back", prev_wr, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h expected no write", w_data);
      end else chk("byte", w_data, exp_q.pop_front());
      got_q.push_back(w_data);
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (frame_done) n_done++;
    prev_wr = wr_uart;
  end

  function automatic logic [7:0] asc(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + 8'(n) : 8'h3F;
  endfunction

  task automatic push_frame(input logic [CH-1:0] m, input logic [16*CH-1:0] d);
    logic [15:0] v;
    for (int i = 0; i < CH; i++) if (m[i]) begin
      v = d[16*i +: 16];
      exp_q.push_back(8'(48 + i / 10));
      exp_q.push_back(8'(48 + i % 10));
      exp_q.push_back(8'h3A);
      exp_q.push_back(asc(v[15:12]));
      exp_q.push_back(8'h2E);
      exp_q.push_back(asc(v[11:8]));
      exp_q.push_back(asc(v[7:4]));
      exp_q.push_back(asc(v[3:0]));
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trigger = 1;
    tick(1);
    trigger = 0;
  endtask

  task automatic rand_din();
    for (int c = 0; c < CH; c++) din[16*c +: 16] = 16'($urandom);
  endtask

  task automatic wait_done(input string name, input int lim);
    int n;
    n = 0;
    while (!frame_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, frame_done, 1);
    tick(1);
  endtask

  task automatic wait_writes(input int target, input int lim);
    int n;
    n = 0;
    while (n_wr < target && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("write_progress", n_wr >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nw, nd, tcyc, t[3], n;
    string s0, s1;
    s0 = "00:3.271 \r\n";
    s1 = "02:0.?05 12:1.000 \r\n";
    vt[0] = '{13'h0001, 16'h3271, 16'h0000, 16'h0000, 11};
    vt[1] = '{13'h1004, 16'h9999, 16'h0A05, 16'h1000, 20};
    vt[2] = '{13'h0000, 16'h1234, 16'h5678, 16'h9ABC, 2};
    vt[3] = '{13'h1FFF, 16'h0123, 16'hFEDC, 16'h4567, 119};
    vt[4] = '{13'h0AAA, 16'h8888, 16'hB0C9, 16'h0000, 56};

    tick(3);
    @(negedge clk);
    chk("rst_w_data", w_data, 0);
    chk("rst_wr_uart", wr_uart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    tick(1);
    rst = 1;
    enable = 1;
    mode = 1;
    tick(2);

    for (int i = 0; i < 5; i++) begin
      rand_din();
      din[15:0] = vt[i].d0;
      din[47:32] = vt[i].d2;
      din[16*12 +: 16] = vt[i].d12;
      ch_mask = vt[i].mask;
      got_q.delete();
      nw = n_wr;
      nd = n_done;
      push_frame(ch_mask, din);
      first_wr = -1;
      tcyc = cyc;
      pulse_trig();
      wait_done("vec_frame_done", 800);
      chk("vec_busy_after", busy, 0);
      chk("vec_nbytes", n_wr - nw, vt[i].nbytes);
      chk("vec_queue_empty", exp_q.size(), 0);
      chk("vec_done_pulses", n_done - nd, 1);
      if (vt[i].mask[0]) chk("vec_first_latency", first_wr - tcyc, 2);
      if (i == 0) for (int j = 0; j < 11; j++) chk("lit_frame0", got_q[j], s0[j]);
      if (i == 1) for (int j = 0; j < 20; j++) chk("lit_frame1", got_q[j], s1[j]);
      tick(3);
    end

    // stall the FIFO for 50 cycles in the middle of channel 0
    ch_mask = 13'h0001;
    din[15:0] = 16'h5068;
    nw = n_wr;
    push_frame(ch_mask, din);
    pulse_trig();
    wait_writes(nw + 3, 100);
    tick(1);
    tx_full = 1;
    tick(1);
    begin
      logic [7:0] wd;
      int wc;
      wd = w_data;
      wc = n_wr;
      tick(50);
      chk("stall_wdata", w_data, wd);
      chk("stall_no_writes", n_wr - wc, 0);
      chk("stall_busy", busy, 1);
    end
    tx_full = 0;
    wait_done("stall_frame_done", 200);
    chk("stall_nbytes", n_wr - nw, 11);
    chk("stall_queue_empty", exp_q.size(), 0);

    // continuous mode with an empty mask: CR LF every PER cycles
    ch_mask = '0;
    nw = n_wr;
    for (int k = 0; k < 3; k++) push_frame(ch_mask, din);
    mode = 0;
    for (int k = 0; k < 3; k++) begin
      wait_done("cont_frame_done", 300);
      t[k] = cyc;
    end
    mode = 1;
    tick(5);
    chk("cont_period_a", t[1] - t[0], PER);
    chk("cont_period_b", t[2] - t[1], PER);
    chk("cont_nbytes", n_wr - nw, 6);
    chk("cont_overrun_clear", overrun, 0);
    chk("cont_queue_empty", exp_q.size(), 0);

    // full mask outlasts the period: next wrap is an overrun
    ch_mask = '1;
    rand_din();
    nw = n_wr;
    push_frame(ch_mask, din);
    mode = 0;
    n = 0;
    while (!overrun && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("cont_overrun_set", overrun, 1);
    tick(1);
    mode = 1;
    wait_done("cont_full_done", 400);
    chk("cont_full_nbytes", n_wr - nw, 119);
    chk("cont_full_queue_empty", exp_q.size(), 0);

    // one-cycle reset while EMIT is held by tx_full
    rand_din();
    push_frame(ch_mask, din);
    nw = n_wr;
    pulse_trig();
    wait_writes(nw + 5, 100);
    tick(1);
    tx_full = 1;
    tick(1);
    rst = 0;
    tick(1);
    rst = 1;
    chk("mid_rst_w_data", w_data, 0);
    chk("mid_rst_wr_uart", wr_uart, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_overrun", overrun, 0);
    exp_q.delete();
    tx_full = 0;
    nw = n_wr;
    tick(10);
    chk("mid_rst_no_writes", n_wr - nw, 0);
    ch_mask = 13'h1004;
    din[47:32] = 16'h0A05;
    din[16*12 +: 16] = 16'h1000;
    got_q.delete();
    push_frame(ch_mask, din);
    pulse_trig();
    wait_done("post_rst_done", 300);
    chk("post_rst_nbytes", n_wr - nw, 20);
    chk("post_rst_queue_empty", exp_q.size(), 0);
    for (int j = 0; j < 20; j++) chk("post_rst_lit", got_q[j], s1[j]);

    // din churns every cycle and a second trigger arrives mid-frame
    ch_mask = 13'h0A5F;
    rand_din();
    nw = n_wr;
    nd = n_done;
    push_frame(ch_mask, din);
    pulse_trig();
    n = 0;
    while (busy && n < 500) begin
      rand_din();
      trigger = n == 20;
      tick(1);
      n++;
    end
    trigger = 0;
    chk("churn_busy_done", busy, 0);
    chk("churn_nbytes", n_wr - nw, 74);
    chk("churn_queue_empty", exp_q.size(), 0);
    chk("churn_done_pulses", n_done - nd, 1);
    chk("churn_overrun", overrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
